// File: rtl/dcsk_symbol_modulator.sv
// Purpose : serial DCSK modulator. Each symbol is a reference slot that forwards beta chaos
//           samples, followed by an information slot that replays them scaled by +1 or -1.
// Latency : 1 cycle from chaos sample acceptance to chip_o; a symbol is exactly 2*beta chips.
// Backpr. : chip_ready_i low freezes the output register and stalls both slots. A chaos gap
//           stalls the reference slot. New bits are refused mid-symbol.
// Ports   : clk/rst_n; bit_valid_i/bit_i/sf_i/bit_ready_o (one bit and spreading factor per
//           symbol); chaos_valid_i/chaos_i/chaos_ready_o (sample stream); chip_valid_o/chip_o/
//           chip_ready_i with sym_first_o/sym_last_o framing; busy_o while a symbol is in flight.

package spreading_factors_pkg;
  typedef enum logic [1:0] {SF2 = 2'd0, SF4 = 2'd1, SF8 = 2'd2, SF16 = 2'd3} sf_t;
endpackage

module dcsk_symbol_modulator
  import spreading_factors_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int MAX_BETA = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  sf_t                      sf_i,
  input  logic                     bit_valid_i,
  input  logic                     bit_i,
  output logic                     bit_ready_o,
  input  logic                     chaos_valid_i,
  input  logic signed [DATA_W-1:0] chaos_i,
  output logic                     chaos_ready_o,
  output logic                     chip_valid_o,
  output logic signed [DATA_W-1:0] chip_o,
  input  logic                     chip_ready_i,
  output logic                     sym_first_o,
  output logic                     sym_last_o,
  output logic                     busy_o
);

  localparam int CW = $clog2(MAX_BETA);
  localparam logic signed [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] S_MAX = ~S_MIN;

  typedef enum logic [1:0] {IDLE, REF, INFO} state_t;

  state_t                    state;
  logic [CW-1:0]             cnt;
  logic [CW-1:0]             last_idx;   // beta-1 of the symbol in flight
  logic                      bit_q;
  logic signed [DATA_W-1:0]  replay_buf [MAX_BETA];

  logic                      out_free;
  logic                      ref_take;
  logic                      info_load;
  logic                      last_load;
  logic                      bit_take;
  logic [CW-1:0]             sf_last_idx;
  logic signed [DATA_W-1:0]  replay_sample;
  logic signed [DATA_W-1:0]  info_chip;

  // The output register can take a new chip when empty or being drained this cycle.
  assign out_free      = !chip_valid_o || chip_ready_i;
  assign chaos_ready_o = (state == REF) && out_free;
  assign ref_take      = chaos_ready_o && chaos_valid_i;
  assign info_load     = (state == INFO) && out_free;
  assign last_load     = info_load && (cnt == last_idx);
  // Accepting the next bit on the final info load lets symbols run back-to-back.
  assign bit_ready_o   = (state == IDLE) || last_load;
  assign bit_take      = bit_valid_i && bit_ready_o;
  assign busy_o        = (state != IDLE);
  assign sf_last_idx   = CW'((32'd2 << sf_i) - 32'd1);

  // Information chip: replay as-is for bit=1, saturating negation for bit=0.
  always_comb begin
    replay_sample = replay_buf[cnt];
    info_chip     = replay_sample;
    if (!bit_q) begin
      if (replay_sample == S_MIN) info_chip = S_MAX;
      else                        info_chip = -replay_sample;
    end
  end

  // Replay storage needs no reset: every entry read in INFO was written in REF first.
  always_ff @(posedge clk) begin
    if (ref_take) replay_buf[cnt] <= chaos_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      last_idx     <= '0;
      bit_q        <= 1'b0;
      chip_valid_o <= 1'b0;
      chip_o       <= '0;
      sym_first_o  <= 1'b0;
      sym_last_o   <= 1'b0;
    end else begin
      // Drain: overridden below if a new chip is loaded in the same cycle.
      if (chip_valid_o && chip_ready_i) begin
        chip_valid_o <= 1'b0;
        sym_first_o  <= 1'b0;
        sym_last_o   <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (bit_take) begin
            bit_q    <= bit_i;
            last_idx <= sf_last_idx;
            cnt      <= '0;
            state    <= REF;
          end
        end
        REF: begin
          if (ref_take) begin
            chip_valid_o <= 1'b1;
            chip_o       <= chaos_i;
            sym_first_o  <= (cnt == '0);
            sym_last_o   <= 1'b0;
            if (cnt == last_idx) begin
              cnt   <= '0;
              state <= INFO;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        INFO: begin
          if (info_load) begin
            chip_valid_o <= 1'b1;
            chip_o       <= info_chip;
            sym_first_o  <= 1'b0;
            sym_last_o   <= last_load;
            if (last_load) begin
              cnt <= '0;
              if (bit_take) begin
                bit_q    <= bit_i;
                last_idx <= sf_last_idx;
                state    <= REF;
              end else begin
                state <= IDLE;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcsk_symbol_modulator.sv
module tb_dcsk_symbol_modulator;
  import spreading_factors_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  sf_t               sf_i;
  logic              bit_valid_i, bit_i, bit_ready_o;
  logic              chaos_valid_i, chaos_ready_o;
  logic signed [7:0] chaos_i;
  logic              chip_valid_o, chip_ready_i;
  logic signed [7:0] chip_o;
  logic              sym_first_o, sym_last_o, busy_o;

  int errors = 0;
  int checks = 0;

  // Stimulus description and collected output
  bit   bits_q[$];
  sf_t  sf_q[$];
  int   chaos_q[$];
  int   got_chip[$];
  bit   got_first[$], got_last[$];
  int   got_cyc[$];
  int   exp_chip[$];
  bit   exp_first[$], exp_last[$];
  int   chaos_used;
  int   cyc;

  dcsk_symbol_modulator #(.DATA_W(8), .MAX_BETA(16)) dut (
    .clk(clk), .rst_n(rst_n), .sf_i(sf_i),
    .bit_valid_i(bit_valid_i), .bit_i(bit_i), .bit_ready_o(bit_ready_o),
    .chaos_valid_i(chaos_valid_i), .chaos_i(chaos_i), .chaos_ready_o(chaos_ready_o),
    .chip_valid_o(chip_valid_o), .chip_o(chip_o), .chip_ready_i(chip_ready_i),
    .sym_first_o(sym_first_o), .sym_last_o(sym_last_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Reference model: per symbol, beta = 2^(sf+1) samples sent as-is, then replayed times +/-1.
  function automatic void build_expected();
    int pos = 0;
    exp_chip.delete(); exp_first.delete(); exp_last.delete();
    foreach (bits_q[k]) begin
      int beta = 1 << (int'(sf_q[k]) + 1);
      for (int j = 0; j < beta; j++) begin
        exp_chip.push_back(chaos_q[pos + j]);
        exp_first.push_back(j == 0);
        exp_last.push_back(1'b0);
      end
      for (int j = 0; j < beta; j++) begin
        int v = chaos_q[pos + j];
        if (!bits_q[k]) v = -v;
        if (v > 127) v = 127;
        exp_chip.push_back(v);
        exp_first.push_back(1'b0);
        exp_last.push_back(j == beta - 1);
      end
      pos += beta;
    end
  endfunction

  task automatic idle_inputs();
    bit_valid_i   = 1'b0;
    bit_i         = 1'b0;
    chaos_valid_i = 1'b0;
    chaos_i       = '0;
    chip_ready_i  = 1'b1;
  endtask

  // Cycle driver: inputs change at negedge, handshakes are read 1ns later and take effect
  // at the following posedge. Also enforces the output hold rule during stalls.
  task automatic drive(input int rpct, input int cvpct, input int stop_after, input int budget);
    int bi = 0, ci = 0, n = 0;
    bit prev_stall = 1'b0, prev_f = 1'b0, prev_l = 1'b0;
    int prev_chip = 0;
    got_chip.delete(); got_first.delete(); got_last.delete(); got_cyc.delete();
    @(negedge clk);
    forever begin
      bit_valid_i   = (bi < bits_q.size());
      bit_i         = bit_valid_i ? bits_q[bi] : 1'($urandom);
      sf_i          = bit_valid_i ? sf_q[bi] : sf_t'($urandom_range(0, 3));
      chaos_valid_i = (ci < chaos_q.size()) && (int'($urandom_range(0, 99)) < cvpct);
      chaos_i       = (ci < chaos_q.size()) ? 8'(chaos_q[ci]) : 8'($urandom);
      chip_ready_i  = (int'($urandom_range(0, 99)) < rpct);
      #1;
      if (prev_stall) begin
        checks++;
        if (chip_valid_o !== 1'b1 || int'(chip_o) !== prev_chip ||
            sym_first_o !== prev_f || sym_last_o !== prev_l) begin
          errors++;
          $display("FAIL hold: vld=%0b chip=%0d first=%0b last=%0b, required vld=1 chip=%0d first=%0b last=%0b",
                   chip_valid_o, chip_o, sym_first_o, sym_last_o, prev_chip, prev_f, prev_l);
        end
      end
      prev_stall = chip_valid_o && !chip_ready_i;
      prev_chip  = int'(chip_o);
      prev_f     = sym_first_o;
      prev_l     = sym_last_o;
      if (bit_valid_i && bit_ready_o) bi++;
      if (chaos_valid_i && chaos_ready_o) ci++;
      if (chip_valid_o && chip_ready_i) begin
        got_chip.push_back(int'(chip_o));
        got_first.push_back(sym_first_o);
        got_last.push_back(sym_last_o);
        got_cyc.push_back(cyc);
      end
      n++;
      cyc++;
      if (got_chip.size() >= stop_after) begin
        @(posedge clk);
        break;
      end
      if (n >= budget) begin
        checks++;
        errors++;
        $display("FAIL timeout: got %0d chips, required %0d", got_chip.size(), stop_after);
        @(posedge clk);
        break;
      end
      @(negedge clk);
    end
    chaos_used = ci;
  endtask

  task automatic test_reset();
    idle_inputs();
    sf_i  = SF2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (chip_valid_o !== 1'b0 || chip_o !== 8'sd0 || sym_first_o !== 1'b0 || sym_last_o !== 1'b0 ||
        busy_o !== 1'b0 || chaos_ready_o !== 1'b0 || bit_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: vld=%0b chip=%0d f=%0b l=%0b busy=%0b crdy=%0b brdy=%0b, required 0 0 0 0 0 0 1",
               chip_valid_o, chip_o, sym_first_o, sym_last_o, busy_o, chaos_ready_o, bit_ready_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_sf2_bit1();
    bits_q = '{1'b1}; sf_q = '{SF2}; chaos_q = '{5, -3};
    exp_chip = '{5, -3, 5, -3};
    exp_first = '{1'b1, 1'b0, 1'b0, 1'b0};
    exp_last  = '{1'b0, 1'b0, 1'b0, 1'b1};
    drive(100, 100, 4, 50);
    idle_inputs();
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= got_chip.size() || got_chip[i] !== exp_chip[i] ||
          got_first[i] !== exp_first[i] || got_last[i] !== exp_last[i]) begin
        errors++;
        $display("FAIL sf2_chip%0d: got %0d, required %0d with first=%0b last=%0b", i,
                 (i < got_chip.size()) ? got_chip[i] : -999, exp_chip[i], exp_first[i], exp_last[i]);
      end
    end
    checks++;
    if (busy_o !== 1'b0 || chip_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL sf2_done: busy=%0b vld=%0b, required 0 0", busy_o, chip_valid_o);
    end
  endtask

  task automatic test_sf4_bit0_sat();
    bits_q = '{1'b0}; sf_q = '{SF4}; chaos_q = '{10, -20, 127, -128};
    exp_chip = '{10, -20, 127, -128, -10, 20, -127, 127};
    drive(100, 100, 8, 60);
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= got_chip.size() || got_chip[i] !== exp_chip[i]) begin
        errors++;
        $display("FAIL sf4_chip%0d: got %0d, required %0d", i,
                 (i < got_chip.size()) ? got_chip[i] : -999, exp_chip[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bits_q = '{1'b1, 1'b0}; sf_q = '{SF8, SF16};
    chaos_q.delete();
    for (int i = 0; i < 24; i++) chaos_q.push_back(int'($urandom_range(0, 255)) - 128);
    build_expected();
    drive(100, 100, 48, 200);
    idle_inputs();
    checks++;
    if (got_chip.size() != 48 || got_chip != exp_chip || got_first != exp_first || got_last != exp_last) begin
      errors++;
      $display("FAIL b2b_seq: got %0d chips, required 48 matching the model", got_chip.size());
    end
    checks++;
    if (got_cyc.size() != 48 || got_cyc[47] - got_cyc[0] != 47) begin
      errors++;
      $display("FAIL b2b_bubble: span %0d cycles, required 47",
               (got_cyc.size() == 48) ? got_cyc[47] - got_cyc[0] : -1);
    end
  endtask

  task automatic test_random_stall();
    bits_q.delete(); sf_q.delete(); chaos_q.delete();
    for (int k = 0; k < 4; k++) begin
      bits_q.push_back(1'($urandom));
      sf_q.push_back(SF16);
    end
    for (int i = 0; i < 64; i++)
      chaos_q.push_back((i % 13 == 5) ? -128 : int'($urandom_range(0, 255)) - 128);
    build_expected();
    drive(50, 70, 128, 3000);
    idle_inputs();
    checks++;
    if (got_chip.size() != 128 || got_chip != exp_chip || got_first != exp_first || got_last != exp_last) begin
      errors++;
      $display("FAIL stall_seq: got %0d chips, required 128 matching the model", got_chip.size());
    end
    checks++;
    if (chaos_used != 64) begin
      errors++;
      $display("FAIL stall_samples: consumed %0d, required 64", chaos_used);
    end
  endtask

  task automatic test_reset_mid();
    bits_q = '{1'b1}; sf_q = '{SF8};
    chaos_q = '{11, 12, 13, 14, 15, 16, 17, 18};
    drive(100, 100, 11, 100);
    // INFO chip 3 is now presented; abort the symbol
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    checks++;
    if (chip_valid_o !== 1'b0 || chip_o !== 8'sd0 || sym_first_o !== 1'b0 || sym_last_o !== 1'b0 ||
        busy_o !== 1'b0 || chaos_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: vld=%0b chip=%0d f=%0b l=%0b busy=%0b crdy=%0b, required all 0",
               chip_valid_o, chip_o, sym_first_o, sym_last_o, busy_o, chaos_ready_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bits_q = '{1'b1}; sf_q = '{SF2}; chaos_q = '{1, 2};
    exp_chip = '{1, 2, 1, 2};
    drive(100, 100, 4, 50);
    idle_inputs();
    checks++;
    if (got_chip.size() != 4 || got_chip != exp_chip || got_first[0] !== 1'b1 || got_last[3] !== 1'b1) begin
      errors++;
      $display("FAIL midreset_restart: got %0d chips first=%0d, required 1,2,1,2",
               got_chip.size(), (got_chip.size() > 0) ? got_chip[0] : -999);
    end
  endtask

  task automatic test_chaos_isolation();
    @(negedge clk);
    chaos_valid_i = 1'b1;
    chaos_i = 8'sd77;
    #1;
    checks++;
    if (chaos_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_chaos_rdy: got %0b, required 0", chaos_ready_o);
    end
    bits_q = '{1'b0}; sf_q = '{SF2}; chaos_q = '{40, -7, 99, 98, 97, 96};
    exp_chip = '{40, -7, -40, 7};
    drive(100, 100, 4, 50);
    idle_inputs();
    checks++;
    if (chaos_used != 2) begin
      errors++;
      $display("FAIL info_chaos_used: consumed %0d, required 2", chaos_used);
    end
    checks++;
    if (got_chip.size() != 4 || got_chip != exp_chip) begin
      errors++;
      $display("FAIL isolation_seq: got %0d chips, required 40,-7,-40,7", got_chip.size());
    end
  endtask

  initial begin
    cyc = 0;
    test_reset();
    test_sf2_bit1();
    test_sf4_bit0_sat();
    test_back_to_back();
    test_random_stall();
    test_reset_mid();
    test_chaos_isolation();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dcsk_symbol_modulator.md
Name: dcsk_symbol_modulator

Overview:
- Serial DCSK modulator stage that consumes one message bit per symbol and a stream of chaotic samples.
- Each symbol is a reference slot of beta chips followed by an information slot of beta chips. The reference slot carries the chaos samples as received. The information slot replays the same samples, multiplied by +1 for bit=1 and by -1 for bit=0.
- beta is set by sf_t from spreading_factors_pkg: SF2/SF4/SF8/SF16 give beta = 2/4/8/16.
- The block sits between the chaos generator and the channel/DAC interface.

Parameters:
- DATA_W, 8, width of chaos samples and output chips (signed two's complement).
- MAX_BETA, 16, capacity of the replay buffer; must be >= 16.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sf_i  in  sf_t  spreading factor; sampled only when a bit is accepted.
- bit_valid_i  in  1  message bit available.
- bit_i  in  1  message bit.
- bit_ready_o  out  1  bit accepted when bit_valid_i && bit_ready_o.
- chaos_valid_i  in  1  chaos sample available.
- chaos_i  in  DATA_W  signed chaos sample.
- chaos_ready_o  out  1  sample accepted when chaos_valid_i && chaos_ready_o.
- chip_valid_o  out  1  output chip valid.
- chip_o  out  DATA_W  signed output chip.
- chip_ready_i  in  1  downstream accepts when chip_valid_o && chip_ready_i.
- sym_first_o  out  1  qualifies the first reference chip of a symbol.
- sym_last_o  out  1  qualifies the last information chip of a symbol.
- busy_o  out  1  high while the FSM is not in IDLE.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - FSM=IDLE; chip_valid_o, chip_o, sym_first_o, sym_last_o, busy_o, chaos_ready_o all 0.
  - bit_ready_o=1 once in IDLE.
  - Chip counter and latched bit/beta are cleared.
  - Reset mid-symbol aborts the symbol. No partial completion is produced after release.
- FSM states are IDLE, REF and INFO.
- IDLE:
  - bit_ready_o=1.
  - On a bit handshake, latch bit_i and beta = 2 << sf_i, clear the counter, and go to REF.
- REF:
  - chaos_ready_o = !chip_valid_o || chip_ready_i.
  - Each accepted sample is written to buffer[cnt] and registered onto chip_o with chip_valid_o=1. Latency is 1 cycle.
  - sym_first_o=1 on the chip with cnt=0.
  - After the beta-th sample is accepted, reset cnt to 0 and go to INFO.
- INFO:
  - chaos_ready_o=0.
  - When !chip_valid_o || chip_ready_i, load chip_o with buffer[cnt] if bit=1, or with its negation if bit=0.
  - Negation saturates: -(-2^(DATA_W-1)) = 2^(DATA_W-1)-1.
  - sym_last_o=1 on chip cnt=beta-1. After loading it, bit_ready_o=1 for that cycle.
  - If a bit handshake occurs on that cycle, go directly to REF (back-to-back symbols, no bubble); otherwise go to IDLE.
- Output register hold rule:
  - While chip_valid_o && !chip_ready_i, chip_o, sym_first_o and sym_last_o hold stable.
  - chip_valid_o drops only after acceptance with no new chip loaded.
- Stall handling:
  - A chaos_valid_i gap in REF stalls the symbol; the counter holds.
  - chip_ready_i low in any state stalls the symbol.
- Handshake isolation:
  - bit_valid_i in REF/INFO (except the final INFO load cycle) is ignored: bit_ready_o=0.
  - Changes on sf_i mid-symbol have no effect.
- Counter width is clog2(MAX_BETA); it wraps to 0 only via the explicit end-of-slot clear.
- Throughput: 1 chip/cycle when chaos_valid_i and chip_ready_i are held high. A symbol takes exactly 2*beta output cycles.

Test Plan:
- Reset, then SF2, bit=1, chaos 5,-3 -> chips 5,-3,5,-3. sym_first_o on chip 0 and sym_last_o on chip 3. busy_o returns to 0 after the last acceptance.
- SF4, bit=0, chaos 10,-20,127,-128 -> chips 10,-20,127,-128,-10,20,-127,127 (the last value is the saturation case).
- Back-to-back: SF8 bit=1 then SF16 bit=0, with bit_valid_i always high -> 16+32 contiguous chip_valid_o cycles and no bubble. The sf_i change mid-symbol is ignored.
- Random chip_ready_i (50%) and chaos_valid_i gaps on SF16 -> chip_o is stable while stalled, the sequence matches the golden model, and no sample is dropped or duplicated.
- Assert rst_n low at INFO chip 3 of an SF8 symbol -> all outputs go to 0 immediately. After release, a new SF2 bit=1 symbol with chaos 1,2 yields exactly 1,2,1,2.
- chaos_valid_i asserted in IDLE/INFO -> chaos_ready_o=0 and no samples are consumed.
